// File: rtl/calendar_ctrl.sv
// Calendar controller: prescales clk into day advances, maintains day/month/year
// with Gregorian leap handling, and serves a validated host set-date handshake.
module calendar_ctrl #(
    parameter int unsigned TICKS_PER_DAY = 86400,
    parameter int unsigned RST_DAY       = 1,
    parameter int unsigned RST_MONTH     = 1,
    parameter int unsigned RST_YEAR      = 2024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        step,
    input  logic        set_valid,
    input  logic [4:0]  set_day,
    input  logic [3:0]  set_month,
    input  logic [11:0] set_year,
    output logic        set_ready,
    output logic        set_err,
    output logic [4:0]  day,
    output logic [3:0]  month,
    output logic [11:0] year,
    output logic        leap_year,
    output logic        new_day,
    output logic        new_month,
    output logic        new_year
);

    localparam int unsigned PW = (TICKS_PER_DAY > 2) ? $clog2(TICKS_PER_DAY) : 1;
    localparam logic [PW-1:0] PrescLast = PW'(TICKS_PER_DAY - 1);

    typedef enum logic [1:0] {StRun, StValidate, StApply} state_e;

    function automatic logic is_leap(input logic [11:0] y);
        return (y[1:0] == 2'b00) && (((y % 12'd100) != 12'd0) || ((y % 12'd400) == 12'd0));
    endfunction

    function automatic logic [4:0] days_in_month(input logic [3:0] m, input logic leap);
        case (m)
            4'd2:                     return leap ? 5'd29 : 5'd28;
            4'd4, 4'd6, 4'd9, 4'd11: return 5'd30;
            default:                  return 5'd31;
        endcase
    endfunction

    state_e        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [4:0]    day_q, day_d, sh_day_q, sh_day_d;
    logic [3:0]    month_q, month_d, sh_month_q, sh_month_d;
    logic [11:0]   year_q, year_d, sh_year_q, sh_year_d;
    logic          new_day_q, new_day_d, new_month_q, new_month_d, new_year_q, new_year_d;
    logic          set_err_q, set_err_d;
    logic          tc;

    assign leap_year = is_leap(year_q);

    always_comb begin
        state_d     = state_q;
        presc_d     = presc_q;
        day_d       = day_q;
        month_d     = month_q;
        year_d      = year_q;
        sh_day_d    = sh_day_q;
        sh_month_d  = sh_month_q;
        sh_year_d   = sh_year_q;
        new_day_d   = 1'b0;
        new_month_d = 1'b0;
        new_year_d  = 1'b0;
        set_err_d   = 1'b0;
        set_ready   = 1'b0;
        tc          = 1'b0;
        unique case (state_q)
            StRun: begin
                set_ready = 1'b1;
                // A capture wins over a coincident advance; prescaler holds.
                if (set_valid) begin
                    sh_day_d   = set_day;
                    sh_month_d = set_month;
                    sh_year_d  = set_year;
                    state_d    = StValidate;
                end else begin
                    if (enable) begin
                        tc      = (presc_q == PrescLast);
                        presc_d = tc ? '0 : presc_q + PW'(1);
                    end
                    if (tc || step) begin
                        new_day_d = 1'b1;
                        if (day_q < days_in_month(month_q, leap_year)) begin
                            day_d = day_q + 5'd1;
                        end else begin
                            day_d       = 5'd1;
                            new_month_d = 1'b1;
                            if (month_q == 4'd12) begin
                                month_d    = 4'd1;
                                year_d     = year_q + 12'd1;
                                new_year_d = 1'b1;
                            end else begin
                                month_d = month_q + 4'd1;
                            end
                        end
                    end
                end
            end
            StValidate: begin
                if ((sh_month_q >= 4'd1) && (sh_month_q <= 4'd12) && (sh_day_q >= 5'd1) &&
                    (sh_day_q <= days_in_month(sh_month_q, is_leap(sh_year_q)))) begin
                    state_d = StApply;
                end else begin
                    set_err_d = 1'b1;
                    state_d   = StRun;
                end
            end
            StApply: begin
                day_d   = sh_day_q;
                month_d = sh_month_q;
                year_d  = sh_year_q;
                presc_d = '0;
                state_d = StRun;
            end
            default: state_d = StRun;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StRun;
            presc_q     <= '0;
            day_q       <= 5'(RST_DAY);
            month_q     <= 4'(RST_MONTH);
            year_q      <= 12'(RST_YEAR);
            sh_day_q    <= '0;
            sh_month_q  <= '0;
            sh_year_q   <= '0;
            new_day_q   <= 1'b0;
            new_month_q <= 1'b0;
            new_year_q  <= 1'b0;
            set_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            presc_q     <= presc_d;
            day_q       <= day_d;
            month_q     <= month_d;
            year_q      <= year_d;
            sh_day_q    <= sh_day_d;
            sh_month_q  <= sh_month_d;
            sh_year_q   <= sh_year_d;
            new_day_q   <= new_day_d;
            new_month_q <= new_month_d;
            new_year_q  <= new_year_d;
            set_err_q   <= set_err_d;
        end
    end

    assign day       = day_q;
    assign month     = month_q;
    assign year      = year_q;
    assign new_day   = new_day_q;
    assign new_month = new_month_q;
    assign new_year  = new_year_q;
    assign set_err   = set_err_q;

endmodule

// File: tb/tb_calendar_ctrl.sv
// Self-checking bench for calendar_ctrl: table of set/step vectors plus hand-written
// sequences for prescaler timing, terminal-count collision and reset abort.
module tb_calendar_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        step = 1'b0;
    logic        set_valid = 1'b0;
    logic [4:0]  set_day = '0;
    logic [3:0]  set_month = '0;
    logic [11:0] set_year = '0;
    logic        set_ready, set_err, leap_year, new_day, new_month, new_year;
    logic [4:0]  day;
    logic [3:0]  month;
    logic [11:0] year;

    calendar_ctrl #(
        .TICKS_PER_DAY(4),
        .RST_DAY(1),
        .RST_MONTH(1),
        .RST_YEAR(2024)
    ) dut (
        .clk(clk),
        .reset(reset),
        .enable(enable),
        .step(step),
        .set_valid(set_valid),
        .set_day(set_day),
        .set_month(set_month),
        .set_year(set_year),
        .set_ready(set_ready),
        .set_err(set_err),
        .day(day),
        .month(month),
        .year(year),
        .leap_year(leap_year),
        .new_day(new_day),
        .new_month(new_month),
        .new_year(new_year)
    );

    always #5 clk = ~clk;

    typedef struct {
        int d; int m; int y;
        int nd; int nm; int ny; int err; int rdy;
    } exp_t;

    typedef struct {
        int d; int m; int y; bit ok;
        int ed; int em; int ey; int enm; int eny;
    } vec_t;

    exp_t exp_q[$];
    vec_t tbl[12];
    int   checks = 0;
    int   errors = 0;
    int   cur_d = 1, cur_m = 1, cur_y = 2024;

    function automatic int is_leap(input int y);
        return ((y % 4 == 0) && (y % 100 != 0)) || (y % 400 == 0) ? 1 : 0;
    endfunction

    function automatic exp_t mk(input int d, m, y, nd, nm, ny, err, rdy);
        exp_t e;
        e.d = d; e.m = m; e.y = y; e.nd = nd; e.nm = nm; e.ny = ny; e.err = err; e.rdy = rdy;
        return e;
    endfunction

    task automatic chk(input string nm, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, expv, $time);
        end
    endtask

    task automatic pop_chk(input string nm);
        exp_t e;
        if (exp_q.size() == 0) begin
            chk({nm, "_sb_empty"}, 0, 1);
        end else begin
            e = exp_q.pop_front();
            chk({nm, ".day"}, int'(day), e.d);
            chk({nm, ".month"}, int'(month), e.m);
            chk({nm, ".year"}, int'(year), e.y);
            chk({nm, ".leap"}, int'(leap_year), is_leap(e.y));
            chk({nm, ".new_day"}, int'(new_day), e.nd);
            chk({nm, ".new_month"}, int'(new_month), e.nm);
            chk({nm, ".new_year"}, int'(new_year), e.ny);
            chk({nm, ".set_err"}, int'(set_err), e.err);
            chk({nm, ".set_ready"}, int'(set_ready), e.rdy);
        end
    endtask

    task automatic set_date(input int d, m, y, input bit ok);
        int k = 0;
        while (!set_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (k == 20) chk("set_ready_timeout", 0, 1);
        set_day = 5'(d); set_month = 4'(m); set_year = 12'(y); set_valid = 1'b1;
        exp_q.push_back(mk(cur_d, cur_m, cur_y, 0, 0, 0, 0, 0));
        if (ok) begin
            exp_q.push_back(mk(cur_d, cur_m, cur_y, 0, 0, 0, 0, 0));
            exp_q.push_back(mk(d, m, y, 0, 0, 0, 0, 1));
        end else begin
            exp_q.push_back(mk(cur_d, cur_m, cur_y, 0, 0, 0, 1, 1));
            exp_q.push_back(mk(cur_d, cur_m, cur_y, 0, 0, 0, 0, 1));
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            set_valid = 1'b0;
            pop_chk(ok ? "set_ok" : "set_reject");
        end
        if (ok) begin
            cur_d = d; cur_m = m; cur_y = y;
        end
    endtask

    task automatic do_step(input int ed, em, ey, enm, eny);
        step = 1'b1;
        exp_q.push_back(mk(ed, em, ey, 1, enm, eny, 0, 1));
        @(negedge clk);
        step = 1'b0;
        pop_chk("step");
        cur_d = ed; cur_m = em; cur_y = ey;
        exp_q.push_back(mk(cur_d, cur_m, cur_y, 0, 0, 0, 0, 1));
        @(negedge clk);
        pop_chk("step_idle");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{28, 2, 2024, 1'b1, 29, 2, 2024, 0, 0};
        tbl[1]  = '{29, 2, 2024, 1'b1, 1, 3, 2024, 1, 0};
        tbl[2]  = '{28, 2, 1900, 1'b1, 1, 3, 1900, 1, 0};
        tbl[3]  = '{28, 2, 2000, 1'b1, 29, 2, 2000, 0, 0};
        tbl[4]  = '{31, 12, 4095, 1'b1, 1, 1, 0, 1, 1};
        tbl[5]  = '{31, 4, 2023, 1'b0, 0, 0, 0, 0, 0};
        tbl[6]  = '{29, 2, 2023, 1'b0, 0, 0, 0, 0, 0};
        tbl[7]  = '{1, 0, 2023, 1'b0, 0, 0, 0, 0, 0};
        tbl[8]  = '{1, 13, 2023, 1'b0, 0, 0, 0, 0, 0};
        tbl[9]  = '{0, 5, 2023, 1'b0, 0, 0, 0, 0, 0};
        tbl[10] = '{30, 4, 2023, 1'b1, 1, 5, 2023, 1, 0};
        tbl[11] = '{31, 1, 2023, 1'b1, 1, 2, 2023, 1, 0};

        // Reset state, then free-running prescaler with TICKS_PER_DAY=4.
        repeat (2) @(negedge clk);
        exp_q.push_back(mk(1, 1, 2024, 0, 0, 0, 0, 1));
        pop_chk("reset");
        reset = 1'b0;
        enable = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            exp_q.push_back(mk(1 + k / 4, 1, 2024, (k % 4 == 0) ? 1 : 0, 0, 0, 0, 1));
            @(negedge clk);
            pop_chk("prescale");
        end
        enable = 1'b0;
        cur_d = 4; cur_m = 1; cur_y = 2024;

        // Leap-day stepping sequence.
        set_date(28, 2, 2024, 1'b1);
        do_step(29, 2, 2024, 0, 0);
        do_step(1, 3, 2024, 1, 0);

        for (int i = 0; i < 12; i++) begin
            set_date(tbl[i].d, tbl[i].m, tbl[i].y, tbl[i].ok);
            if (tbl[i].ok) do_step(tbl[i].ed, tbl[i].em, tbl[i].ey, tbl[i].enm, tbl[i].eny);
        end

        // Set request landing on the terminal-count edge.
        enable = 1'b1;
        set_date(15, 5, 2023, 1'b1);
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back(mk(cur_d, cur_m, cur_y, 0, 0, 0, 0, 1));
            @(negedge clk);
            pop_chk("tc_prep");
        end
        set_date(10, 6, 2023, 1'b1);
        for (int k = 1; k <= 4; k++) begin
            if (k == 4) exp_q.push_back(mk(11, 6, 2023, 1, 0, 0, 0, 1));
            else exp_q.push_back(mk(10, 6, 2023, 0, 0, 0, 0, 1));
            @(negedge clk);
            pop_chk("tc_restart");
        end
        cur_d = 11;
        enable = 1'b0;

        // Reset asserted while a (bad) request sits in VALIDATE.
        set_day = 5'd31; set_month = 4'd4; set_year = 12'd2023; set_valid = 1'b1;
        exp_q.push_back(mk(cur_d, cur_m, cur_y, 0, 0, 0, 0, 0));
        @(negedge clk);
        set_valid = 1'b0;
        pop_chk("abort_accept");
        reset = 1'b1;
        #1;
        exp_q.push_back(mk(1, 1, 2024, 0, 0, 0, 0, 1));
        pop_chk("abort_async");
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back(mk(1, 1, 2024, 0, 0, 0, 0, 1));
            @(negedge clk);
            pop_chk("abort_after");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/calendar_ctrl.md
Name: calendar_ctrl

Overview:
Controller that sequences the calendar datapath: prescales the system clock into day-advance events and keeps day/month/year registers consistent. It computes the Gregorian leap-year flag and serves a validated set-date handshake from the host. It sits between the system clock domain and display/alarm logic, which consume the date fields and the rollover pulses.

Parameters:
TICKS_PER_DAY, 86400, clk cycles per day advance (>=2)
RST_DAY, 1, day value after reset (1..31)
RST_MONTH, 1, month value after reset (1..12)
RST_YEAR, 2024, year value after reset (0..4095)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
enable  in  1  prescaler counts only when high
step  in  1  single-cycle request: advance one day immediately (test/fast-forward)
set_valid  in  1  host set-date request
set_day  in  5  requested day
set_month  in  4  requested month
set_year  in  12  requested year
set_ready  out  1  controller accepts a set request this cycle
set_err  out  1  1-cycle pulse: the last request was rejected
day  out  5  current day, 1..31
month  out  4  current month, 1..12
year  out  12  current year, 0..4095
leap_year  out  1  combinational Gregorian leap flag for the current year
new_day  out  1  1-cycle pulse on every day advance
new_month  out  1  1-cycle pulse when day wraps to 1
new_year  out  1  1-cycle pulse when month wraps Dec->Jan

Behaviour:
- Reset (async, high): day=RST_DAY, month=RST_MONTH, year=RST_YEAR, prescaler=0, state=RUN, set_ready=1, all pulses and set_err=0.
- leap_year = (year%4==0) && (year%100!=0 || year%400==0).
- days_in_month: Feb = 28+leap; Apr/Jun/Sep/Nov = 30; all others 31.
- FSM states: RUN, VALIDATE, APPLY.
- RUN:
  - set_ready=1.
  - When enable=1, prescaler increments. At TICKS_PER_DAY-1 it returns to 0 and raises an advance.
  - step=1 also raises an advance. If step coincides with terminal count, exactly one advance occurs.
  - Advance:
    - day<days_in_month: day+1.
    - Otherwise day=1 and month+1, or month=1 and year+1 when month==12.
    - year wraps 4095->0.
  - Pulses are registered and coincide with the updated fields (same edge). new_year implies new_month implies new_day.
  - set_valid&&set_ready: capture set_* into shadow registers and go to VALIDATE. Capture takes priority over an advance in the same cycle; that advance is discarded, and the prescaler holds its value.
- VALIDATE (1 cycle):
  - set_ready=0; prescaler frozen; step ignored.
  - Valid request: 1<=month<=12 and 1<=day<=days_in_month, evaluated with the leap flag of the shadow year. Go to APPLY.
  - Invalid request: set_err=1 for one cycle, date unchanged, return to RUN.
- APPLY (1 cycle):
  - Load day/month/year from the shadow registers, prescaler=0, no rollover pulses, return to RUN.
  - set_ready returns high the cycle after APPLY.
- Set-to-first-advance latency: a new date is visible 2 cycles after the accepting edge. The first day advance follows TICKS_PER_DAY enabled cycles later.
- set_valid while set_ready=0 is ignored; the host must hold the request until ready.
- Reset mid-VALIDATE/APPLY aborts the request; the shadow registers are discarded.
- enable=0 freezes the prescaler only; step and set requests remain functional.

Test Plan:
1. TICKS_PER_DAY=4, reset, enable=1 -> day 1->2 after 4 cycles; new_day pulses once per 4 cycles; new_month stays 0.
2. Set 28/2/2024, step once -> 29/2; step again -> 1/3 with new_month=1, new_year=0. Set 28/2/1900, step -> 1/3 (1900 not leap); 28/2/2000, step -> 29/2.
3. Set 31/12/4095, step -> 1/1/0 with new_day, new_month and new_year asserted on the same cycle.
4. Set 31/4/2023 -> set_err pulses 1 cycle, date unchanged, set_ready back to 1. Set 29/2/2023 -> rejected. Month 0 or 13 -> rejected.
5. set_valid in the same cycle as terminal count -> date equals the set value, no new_day pulse, prescaler restarts at 0, next advance 4 cycles after APPLY.
6. Assert reset during VALIDATE -> outputs return to RST_* immediately (async), set_err never pulses, state=RUN.
